// File: rtl/conv2_act_expand.sv
// Expands 8-bit conv2 activation codes {sign, acc[9:3]} back to 16-bit fixed-point words,
// behind a 2-entry elastic buffer with per-feature-map last/done framing.
module conv2_act_expand #(
    parameter int unsigned FRAME_LEN = 144,
    parameter bit          RELU_EN   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        m_last,
    output logic        frame_done,
    output logic [15:0] elem_idx
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    logic [1:0]  count_q, count_d;
    logic [15:0] head_q, head_d;
    logic [15:0] skid_q, skid_d;
    logic [15:0] idx_q, idx_d;
    logic        done_q, done_d;
    logic [15:0] exp_word;
    logic        push, pop;

    always_comb begin
        if (RELU_EN && s_data[7]) begin
            exp_word = 16'h0000;
        end else begin
            exp_word = {{6{s_data[7]}}, s_data[6:0], 3'b000};
        end
    end

    // Ready depends only on registered occupancy so there is no s_ready <- m_ready path.
    assign s_ready    = (count_q != 2'd2);
    assign m_valid    = (count_q != 2'd0);
    assign push       = s_valid && s_ready;
    assign pop        = m_valid && m_ready;
    assign m_data     = head_q;
    assign elem_idx   = idx_q;
    assign m_last     = m_valid && (idx_q == LAST_IDX);
    assign frame_done = done_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        idx_d   = idx_q;
        done_d  = pop && m_last;

        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d  = exp_word;
                    count_d = 2'd1;
                end else begin
                    skid_d  = exp_word;
                    count_d = 2'd2;
                end
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = skid_q;
                end
                count_d = count_q - 2'd1;
            end
            // Push and pop together only happen at count 1: the new word replaces the head.
            2'b11: head_d = exp_word;
            default: ;
        endcase

        if (pop) begin
            idx_d = m_last ? 16'd0 : idx_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            // NOTE: data registers are reset too, so m_data reads 0 (not X) before the first word.
            head_q  <= 16'h0000;
            skid_q  <= 16'h0000;
            idx_q   <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            count_q <= count_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_conv2_act_expand.sv
// Self-checking bench for conv2_act_expand: vector table, hand-written corner sequences
// and a randomized stream compared against a queue-based reference model.
module tb_conv2_act_expand;

    localparam int FL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        s_valid, s_ready, m_valid, m_ready, m_last, frame_done;
    logic [7:0]  s_data;
    logic [15:0] m_data, elem_idx;

    logic        r_s_valid, r_s_ready, r_m_valid, r_m_ready, r_m_last, r_frame_done;
    logic [7:0]  r_s_data;
    logic [15:0] r_m_data, r_elem_idx;

    conv2_act_expand #(.FRAME_LEN(FL), .RELU_EN(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .frame_done(frame_done), .elem_idx(elem_idx)
    );

    conv2_act_expand #(.FRAME_LEN(1), .RELU_EN(1'b1)) u_relu (
        .clk(clk), .rst_n(rst_n),
        .s_valid(r_s_valid), .s_ready(r_s_ready), .s_data(r_s_data),
        .m_valid(r_m_valid), .m_ready(r_m_ready), .m_data(r_m_data),
        .m_last(r_m_last), .frame_done(r_frame_done), .elem_idx(r_elem_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the code is a signed 8-bit value of acc/8, so the word is simply code*8.
    function automatic logic [15:0] ref_expand(input logic [7:0] code, input bit relu);
        int v;
        v = int'($signed(code)) * 8;
        if (relu && v < 0) v = 0;
        return 16'(v);
    endfunction

    typedef struct {
        logic [7:0]  code;
        logic [15:0] exp_lin;
        logic [15:0] exp_relu;
    } vec_t;

    vec_t vecs[8];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        r_s_valid = 1'b0; r_s_data = 8'h00; r_m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Streams n codes back to back with m_ready high and checks data and framing every cycle.
    task automatic run_frame(input int n, input logic [7:0] base);
        m_ready = 1'b1;
        for (int k = 0; k <= n + 1; k++) begin
            if (k < n) begin
                s_valid = 1'b1;
                s_data  = base + 8'(k);
            end else begin
                s_valid = 1'b0;
            end
            if (k >= 1 && k <= n) begin
                check("frm_valid", m_valid, 1'b1);
                check("frm_data", m_data, ref_expand(base + 8'(k - 1), 1'b0));
                check("frm_idx", elem_idx, 32'((k - 1) % FL));
                check("frm_last", m_last, ((k - 1) % FL) == FL - 1);
            end
            check("frm_done", frame_done, (k >= 2) && (((k - 2) % FL) == FL - 1));
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got[$];
        logic [15:0] q[$];
        int sent, out_cnt;
        bit fd_exp, stall_prev, pushed_prev, push, pop;
        logic [15:0] prev_data;

        vecs[0] = '{8'h25, 16'h0128, 16'h0128};
        vecs[1] = '{8'hA5, 16'hFD28, 16'h0000};
        vecs[2] = '{8'h7F, 16'h03F8, 16'h03F8};
        vecs[3] = '{8'h80, 16'hFC00, 16'h0000};
        vecs[4] = '{8'h00, 16'h0000, 16'h0000};
        vecs[5] = '{8'h01, 16'h0008, 16'h0008};
        vecs[6] = '{8'hFF, 16'hFFF8, 16'h0000};
        vecs[7] = '{8'h40, 16'h0200, 16'h0200};

        // Reset state
        do_reset();
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 16'h0000);
        check("rst_m_last", m_last, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_elem_idx", elem_idx, 16'd0);

        // Vector table: expansion, 1-cycle latency, hold when idle, framing on both instances
        m_ready = 1'b1; r_m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("tbl_pre_valid", m_valid, 1'b0);
            s_valid = 1'b1; s_data = vecs[i].code;
            r_s_valid = 1'b1; r_s_data = vecs[i].code;
            @(negedge clk);
            s_valid = 1'b0; r_s_valid = 1'b0;
            check("tbl_valid", m_valid, 1'b1);
            check("tbl_data", m_data, vecs[i].exp_lin);
            check("tbl_idx", elem_idx, 32'(i % FL));
            check("tbl_last", m_last, (i % FL) == FL - 1);
            check("tbl_relu_valid", r_m_valid, 1'b1);
            check("tbl_relu_data", r_m_data, vecs[i].exp_relu);
            check("tbl_relu_last", r_m_last, 1'b1);
            check("tbl_relu_idx", r_elem_idx, 16'd0);
            @(negedge clk);
            check("tbl_done", frame_done, (i % FL) == FL - 1);
            check("tbl_relu_done", r_frame_done, 1'b1);
            check("tbl_post_valid", m_valid, 1'b0);
            check("tbl_hold_data", m_data, vecs[i].exp_lin);
        end

        // Backpressure: two accepted, third held upstream, then drained in order
        do_reset();
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'h01;
        @(negedge clk);
        check("bp_ready_after1", s_ready, 1'b1);
        s_data = 8'h02;
        @(negedge clk);
        check("bp_ready_after2", s_ready, 1'b0);
        s_data = 8'h03;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("bp_stall_ready", s_ready, 1'b0);
            check("bp_stall_valid", m_valid, 1'b1);
            check("bp_stall_data", m_data, 16'h0008);
            check("bp_stall_idx", elem_idx, 16'd0);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            push = s_valid && s_ready;
            if (m_valid && m_ready) got.push_back(m_data);
            @(negedge clk);
            if (push) s_valid = 1'b0;
        end
        s_valid = 1'b0;
        check("bp_count", got.size(), 3);
        for (int j = 0; j < 3; j++) begin
            check("bp_order", (j < got.size()) ? got[j] : 16'hxxxx, ref_expand(8'(j + 1), 1'b0));
        end

        // Framing: two full frames streamed at full rate
        do_reset();
        run_frame(8, 8'h31);

        // Reset mid-stream with count=2 and elem_idx=2
        do_reset();
        m_ready = 1'b1; s_valid = 1'b1; s_data = 8'h11;
        @(negedge clk); s_data = 8'h12;
        @(negedge clk); s_data = 8'h13;
        @(negedge clk); m_ready = 1'b0; s_data = 8'h14;
        @(negedge clk); s_valid = 1'b0;
        check("mid_full", s_ready, 1'b0);
        check("mid_valid", m_valid, 1'b1);
        check("mid_idx", elem_idx, 16'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", m_valid, 1'b0);
        check("mid_rst_idx", elem_idx, 16'd0);
        check("mid_rst_data", m_data, 16'h0000);
        check("mid_rst_last", m_last, 1'b0);
        @(negedge clk);
        check("mid_rst_done", frame_done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", s_ready, 1'b1);
        check("mid_rel_valid", m_valid, 1'b0);
        check("mid_rel_done", frame_done, 1'b0);
        run_frame(FL, 8'h90);

        // Randomized stream against the queue model
        do_reset();
        sent = 0; out_cnt = 0; fd_exp = 1'b0; stall_prev = 1'b0; pushed_prev = 1'b0;
        prev_data = 16'h0000;
        for (int cyc = 0; cyc < 20000 && !(sent == 1000 && out_cnt == 1000); cyc++) begin
            check("rnd_m_valid", m_valid, q.size() != 0);
            check("rnd_s_ready", s_ready, q.size() < 2);
            check("rnd_done", frame_done, fd_exp);
            if (m_valid && q.size() != 0) begin
                check("rnd_data", m_data, q[0]);
                check("rnd_idx", elem_idx, 32'(out_cnt % FL));
                check("rnd_last", m_last, (out_cnt % FL) == FL - 1);
            end
            if (stall_prev) check("rnd_stable", m_data, prev_data);

            if (pushed_prev) s_valid = 1'b0;
            if (!s_valid && sent < 1000 && $urandom_range(1) == 1) begin
                s_valid = 1'b1;
                s_data  = 8'($urandom);
            end
            m_ready = ($urandom_range(1) == 1);

            push = s_valid && s_ready;
            pop  = m_valid && m_ready;
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            fd_exp = pop && ((out_cnt % FL) == FL - 1);
            if (pop && q.size() != 0) begin
                void'(q.pop_front());
                out_cnt++;
            end
            if (push) begin
                q.push_back(ref_expand(s_data, 1'b0));
                sent++;
            end
            pushed_prev = push;
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("rnd_all_out", out_cnt, 1000);
        check("rnd_all_in", sent, 1000);
        check("rnd_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv2_act_expand.md
Name: conv2_act_expand

Overview:
- Streaming expander that turns the 8-bit activation codes written by the conv-layer-2 activation stage back into the 16-bit fixed-point word format the next layer's PE inputs consume.
- Code format: bit7 = sign, bits6:0 = accumulator bits 9:3. This block is the exact inverse mapping.
- Adds valid/ready handshakes on both sides, a 2-entry elastic buffer, and per-feature-map framing (last/done flags).
- Sits between the activation buffer read port and the next layer's PE input FIFO.

Parameters:
- FRAME_LEN, 144, number of activations per feature map; range 1..65535.
- RELU_EN, 0, when 1 any code with sign bit set expands to 16'h0000.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- s_valid  input  1  upstream code valid
- s_ready  output  1  block can accept a code this cycle
- s_data  input  8  activation code {sign, mag[6:0]}
- m_valid  output  1  expanded word valid
- m_ready  input  1  downstream accepts word this cycle
- m_data  output  16  expanded fixed-point word
- m_last  output  1  high with the final word of a feature map
- frame_done  output  1  one-cycle pulse after the last word of a frame is accepted
- elem_idx  output  16  index of the word currently on m_data within its frame

Behaviour:
- Reset (async assert, sync release): buffer empty, m_valid=0, m_data=0, m_last=0, frame_done=0, elem_idx=0, s_ready=1 on the first cycle after release.
- Expansion (combinational, before buffer write), with s = s_data[7]:
  - m_data = {6{s}}, s_data[6:0], 3'b000.
  - RELU_EN=1 and s=1 -> 16'h0000.
  - No rounding; the low 3 bits are always 0.
- Handshakes:
  - push when s_valid&&s_ready; pop when m_valid&&m_ready.
  - s_data is sampled only on push. m_data, m_last and elem_idx hold stable while m_valid=1 and m_ready=0.
- Buffer: 2-entry FIFO (registered stage plus skid), count 0..2.
  - s_ready = (count!=2), derived from registered count only, never from m_ready.
  - m_valid = (count!=0).
  - Latency: a code pushed at edge N is presented at edge N, valid in cycle N+1 if the buffer was empty.
  - Sustained throughput is 1 word/cycle when m_ready is held high.
- Simultaneous events:
  - count=1 with push and pop: count stays 1, new word moves to the head next cycle, order preserved.
  - count=0: a push is not bypassed combinationally to m_data.
  - count=2: no push is possible.
- Framing: output-side counter elem_idx increments on each pop.
  - m_last = (elem_idx==FRAME_LEN-1) && m_valid.
  - A pop with m_last=1 wraps elem_idx to 0 and sets frame_done=1 for exactly the next cycle.
  - FRAME_LEN=1 makes every word last.
- Reset mid-operation: buffered words are discarded, the counter is cleared, and no frame_done is emitted for the partial frame.
- No X propagation: with m_valid=0, m_data holds its last value (0 after reset).

Test Plan:
- Basic expand, RELU_EN=0: push 8'h25 -> m_data 16'h0128; push 8'hA5 -> 16'hFD28; 8'h7F -> 16'h03F8; 8'h80 -> 16'hFC00; 8'h00 -> 16'h0000. Latency exactly 1 cycle with m_ready=1.
- ReLU, RELU_EN=1: push 8'hA5 -> 16'h0000; 8'h25 -> 16'h0128.
- Backpressure, m_ready=0, push 8'h01, 8'h02, 8'h03 back-to-back:
  - First two accepted; s_ready drops after the second; the third is held upstream.
  - Raise m_ready -> output sequence 16'h0008, 16'h0010, 16'h0018 in order, no loss or duplication.
- Framing, FRAME_LEN=4, 8 codes streamed, m_ready=1:
  - m_last high on the 4th and 8th words; elem_idx runs 0,1,2,3,0,1,2,3.
  - frame_done pulses once, one cycle after each last pop.
- Random stall: 1000 random codes with random s_valid/m_ready (50%) -> output matches the reference expansion in order, and m_data is stable during every stall.
- Reset mid-stream, FRAME_LEN=4: assert rst_n=0 with count=2 and elem_idx=2 -> m_valid=0 and elem_idx=0 immediately. After release, the next 4 words produce m_last on the 4th.
